// File: rtl/timeout_scheduler_pkg.sv
// Shared state encoding, default sizes and helpers for the timeout scheduler.
package timeout_scheduler_pkg;

    localparam int TS_NUM_REQ       = 4;
    localparam int TS_COUNTER_WIDTH = 8;
    localparam int IDX_W            = $clog2(TS_NUM_REQ);
    localparam int MAX_REQ          = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [4:0] onehot_to_index(input logic [MAX_REQ-1:0] onehot);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/timeout_scheduler_rr_arbiter.sv
// Combinational winner selection for the shared timer.
// TIMEOUT_SCHEDULER_FIXED_PRIO_EN: lowest index wins and rr_ptr is ignored.
module timeout_scheduler_rr_arbiter
    import timeout_scheduler_pkg::*;
#(
    parameter int NUM_REQ = TS_NUM_REQ,
    parameter int IW      = IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] rot_s;
    int                 base_s;
    int                 sum_s;

`ifdef TIMEOUT_SCHEDULER_FIXED_PRIO_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ^rr_ptr;
    assign rot_s        = req;
    assign base_s       = 0;
`else
    logic [2*NUM_REQ-1:0] dbl_s;
    // Rotate so that bit 0 of rot_s is the requester at rr_ptr.
    assign dbl_s  = {req, req};
    assign rot_s  = NUM_REQ'(dbl_s >> rr_ptr);
    assign base_s = int'(rr_ptr);
`endif

    // Lowest set bit of the rotated vector wins; map it back to a requester index.
    always_comb begin
        winner = {IW{1'b0}};
        sum_s  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                sum_s = base_s + i;
                if (sum_s >= NUM_REQ) begin
                    winner = IW'(sum_s - NUM_REQ);
                end else begin
                    winner = IW'(sum_s);
                end
            end else begin
                winner = winner;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/timeout_scheduler.sv
// One countdown timer shared by NUM_REQ requesters: arbitrate, load, count, pulse done.
// TIMEOUT_SCHEDULER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module timeout_scheduler
    import timeout_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = TS_NUM_REQ,
    parameter int COUNTER_WIDTH = TS_COUNTER_WIDTH
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*COUNTER_WIDTH-1:0] value,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               done,
    output logic                             busy,
    output logic [COUNTER_WIDTH-1:0]         counter
);

    localparam int REQ_IDX_W = $clog2(NUM_REQ);

    state_e                   state_r, state_nxt_s;
    logic [NUM_REQ-1:0]       grant_r, grant_nxt_s;
    logic [NUM_REQ-1:0]       done_r, done_nxt_s;
    logic [COUNTER_WIDTH-1:0] counter_r, counter_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic [COUNTER_WIDTH-1:0] load_val_s;
    logic [REQ_IDX_W-1:0]     rr_ptr_s;
    logic [REQ_IDX_W-1:0]     winner_s;
    logic                     win_valid_s;
    logic                     owner_req_s;

    timeout_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (REQ_IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_s),
        .winner (winner_s),
        .valid  (win_valid_s)
    );

`ifdef TIMEOUT_SCHEDULER_FIXED_PRIO_EN
    assign rr_ptr_s = {REQ_IDX_W{1'b0}};
`else
    logic [REQ_IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;

    // Pointer moves just past each new owner so it queues behind the others.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        if (state_r == IDLE && win_valid_s) begin
            if (winner_s == REQ_IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_nxt_s = {REQ_IDX_W{1'b0}};
            end else begin
                rr_ptr_nxt_s = winner_s + REQ_IDX_W'(1);
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= {REQ_IDX_W{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign rr_ptr_s = rr_ptr_r;
`endif

    // Reload count of the current arbitration winner.
    always_comb begin
        load_val_s = {COUNTER_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == REQ_IDX_W'(i)) begin
                load_val_s = value[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end else begin
                load_val_s = load_val_s;
            end
        end
    end

    assign owner_req_s = |(req & grant_r);

    // State and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_r   <= {NUM_REQ{1'b0}};
            done_r    <= {NUM_REQ{1'b0}};
            counter_r <= {COUNTER_WIDTH{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            done_r    <= done_nxt_s;
            counter_r <= counter_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Next-state logic; abort takes precedence over expiry in RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!win_valid_s) begin
                    state_nxt_s = IDLE;
                end else if (load_val_s == {COUNTER_WIDTH{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (!owner_req_s) begin
                    state_nxt_s = IDLE;
                end else if (counter_r <= COUNTER_WIDTH'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_nxt_s   = grant_r;
        counter_nxt_s = counter_r;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    grant_nxt_s   = NUM_REQ'(1) << winner_s;
                    counter_nxt_s = load_val_s;
                end else begin
                    grant_nxt_s   = {NUM_REQ{1'b0}};
                end
            end
            RUN: begin
                if (!owner_req_s) begin
                    grant_nxt_s   = {NUM_REQ{1'b0}};
                    counter_nxt_s = {COUNTER_WIDTH{1'b0}};
                end else if (counter_r <= COUNTER_WIDTH'(1)) begin
                    counter_nxt_s = {COUNTER_WIDTH{1'b0}};
                end else begin
                    counter_nxt_s = counter_r - COUNTER_WIDTH'(1);
                end
            end
            DONE: begin
                grant_nxt_s = {NUM_REQ{1'b0}};
            end
            default: begin
                grant_nxt_s   = {NUM_REQ{1'b0}};
                counter_nxt_s = {COUNTER_WIDTH{1'b0}};
            end
        endcase
        if (state_nxt_s == DONE) begin
            done_nxt_s = grant_nxt_s;
        end else begin
            done_nxt_s = {NUM_REQ{1'b0}};
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    assign grant   = grant_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign counter = counter_r;

endmodule

// File: tb/tb_timeout_scheduler.sv
// Scoreboard bench for timeout_scheduler: each granted request pushes its expected done owner and latency.
module tb_timeout_scheduler;

    localparam int NR = 4;
    localparam int CW = 8;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  value;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [CW-1:0]     counter;

    typedef struct {
        logic [NR-1:0] oh;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    timeout_scheduler #(.NUM_REQ(NR), .COUNTER_WIDTH(CW)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (req),
        .value   (value),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .counter (counter)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [NR-1:0] oh, input int lat);
        exp_t e;
        e.oh  = oh;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: measure grant-to-done latency and compare every done pulse with the scoreboard.
    int            lat_cnt = 0;
    logic [NR-1:0] prev_grant = '0;
    initial begin
        forever begin
            @(negedge clk_in);
            if (reset) begin
                lat_cnt    = 0;
                prev_grant = '0;
            end else begin
                if (grant != '0 && prev_grant == '0) lat_cnt = 0;
                else if (grant != '0) lat_cnt++;
                prev_grant = grant;
                if (done != '0) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_eq("done_owner", 32'(done), 32'(e.oh));
                        check_eq("grant_at_done", 32'(grant), 32'(e.oh));
                        check_eq("counter_at_done", 32'(counter), 32'd0);
                        check_eq("busy_at_done", 32'(busy), 32'd1);
                        check_eq("latency", 32'(lat_cnt), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic wait_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk_in);
            if (done != '0) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        req = '0;
    endtask

    task automatic single_req(input int idx, input int v, input bit alter);
        @(negedge clk_in);
        req = NR'(1) << idx;
        value[idx*CW +: CW] = CW'(v);
        push_exp(NR'(1) << idx, v);
        for (int j = 0; j <= v; j++) begin
            @(negedge clk_in);
            check_eq("count", 32'(counter), 32'(v - j));
            check_eq("grant_held", 32'(grant), 32'(NR'(1) << idx));
            if (alter && j == 1) value[idx*CW +: CW] = CW'(v + 4);
        end
        req = '0;
        @(negedge clk_in);
        check_eq("grant_release", 32'(grant), 32'd0);
        check_eq("busy_release", 32'(busy), 32'd0);
        check_eq("done_release", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] rr_order [5];
        int            n;
`ifdef TIMEOUT_SCHEDULER_FIXED_PRIO_EN
        rr_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        reset = 1'b1;
        req   = '0;
        value = '0;
        #12;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_counter", 32'(counter), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;

        // Contention: all four requesters pending with count 2.
        value = {4{8'd2}};
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(rr_order[i], 2);
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
            @(negedge clk_in);
            if (done != '0) n++;
        end
        check_eq("rr_done_count", 32'(n), 32'd5);
        req = '0;

        single_req(0, 5, 1'b0);
        single_req(1, 0, 1'b0);
        single_req(0, 5, 1'b1);

        // Abort: requester 2 drops its request with 7 counts left.
        @(negedge clk_in);
        req = 4'b0100;
        value[2*CW +: CW] = 8'd10;
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk_in);
            check_eq("abort_count", 32'(counter), 32'(10 - j));
        end
        req = '0;
        @(negedge clk_in);
        check_eq("abort_counter", 32'(counter), 32'd0);
        check_eq("abort_grant", 32'(grant), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk_in);

        // Asynchronous reset in the middle of a countdown.
        req = 4'b0001;
        value[0 +: CW] = 8'd10;
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk_in);
            check_eq("prerst_count", 32'(counter), 32'(10 - j));
        end
        #2;
        reset = 1'b1;
        req   = 4'b1000;
        value[3*CW +: CW] = 8'd3;
        #1;
        check_eq("arst_grant", 32'(grant), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_counter", 32'(counter), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        push_exp(4'b1000, 3);
        @(negedge clk_in);
        check_eq("postrst_grant", 32'(grant), 32'b1000);
        check_eq("postrst_counter", 32'(counter), 32'd3);
        wait_done(10);

        repeat (3) @(negedge clk_in);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
